// File: rtl/trdb_pkg.sv
// rtl/trdb_pkg.sv - shared types and sizing for the buffered trace packet emitter (TRDB_EMIT_TIME_EN adds the time field)
package trdb_pkg;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'd0,
        F_DIFF_DELTA = 2'd1,
        F_ADDR_ONLY  = 2'd2,
        F_SYNC       = 2'd3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START     = 2'd0,
        SF_EXCEPTION = 2'd1,
        SF_CONTEXT   = 2'd2,
        SF_SUPPORT   = 2'd3
    } trdb_f_sync_subformat_e;

    localparam int unsigned DEF_XLEN      = 32;
    localparam int unsigned DEF_PRIV_LEN  = 2;
    localparam int unsigned DEF_CAUSE_LEN = 5;
    localparam int unsigned DEF_TVAL_LEN  = 32;
    localparam int unsigned DEF_BMAP_LEN  = 31;
    localparam int unsigned DEF_TIME_W    = 16;
    localparam int unsigned DEF_BCNT_LEN  = $clog2(DEF_BMAP_LEN + 1);

    // The two candidates for the widest packet: sync/exception and branch map with address.
    localparam int unsigned SYNC_EXC_W = 4 + 1 + DEF_PRIV_LEN + DEF_CAUSE_LEN + 2 + DEF_XLEN + DEF_TVAL_LEN;
    localparam int unsigned BRANCH_W   = 2 + DEF_BCNT_LEN + DEF_BMAP_LEN + DEF_XLEN + 3;

`ifdef TRDB_EMIT_TIME_EN
    localparam int unsigned TIME_FIELD_W = DEF_TIME_W;
`else
    localparam int unsigned TIME_FIELD_W = 0;
`endif

    localparam int unsigned PAYLOAD_W = ((SYNC_EXC_W > BRANCH_W) ? SYNC_EXC_W : BRANCH_W) + TIME_FIELD_W;
    localparam int unsigned LEN_W     = 5;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [LEN_W-1:0]     length;
    } emitter_entry_t;

endpackage

// File: rtl/trdb_pkt_fifo.sv
// rtl/trdb_pkt_fifo.sv - generic entry queue with full/empty flags and same-cycle push/pop
module trdb_pkt_fifo #(
    parameter type         entry_t = logic,
    parameter int unsigned DEPTH   = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/trdb_packet_emitter_q.sv
// rtl/trdb_packet_emitter_q.sv - assembles format 1/2/3 trace payloads into a queue; TRDB_EMIT_TIME_EN adds a timestamp
module trdb_packet_emitter_q
    import trdb_pkg::*;
#(
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned PRIV_LEN   = DEF_PRIV_LEN,
    parameter int unsigned CAUSE_LEN  = DEF_CAUSE_LEN,
    parameter int unsigned TVAL_LEN   = DEF_TVAL_LEN,
    parameter int unsigned BMAP_LEN   = DEF_BMAP_LEN,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIME_W     = DEF_TIME_W
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    input  logic [1:0]                    format_i,
    input  logic [1:0]                    subformat_i,
    input  logic                          full_address_i,
    input  logic                          branch_i,
    input  logic [PRIV_LEN-1:0]           priv_i,
    input  logic [XLEN-1:0]               iaddr_i,
    input  logic [CAUSE_LEN-1:0]          cause_i,
    input  logic                          interrupt_i,
    input  logic                          thaddr_i,
    input  logic [TVAL_LEN-1:0]           tval_i,
    input  logic                          updiscon_i,
    input  logic [$clog2(BMAP_LEN+1)-1:0] branches_i,
    input  logic [BMAP_LEN-1:0]           branch_map_i,
    input  logic                          ienable_i,
    input  logic                          encoder_mode_i,
    input  logic [1:0]                    qual_status_i,
    input  logic [2:0]                    ioptions_i,
    input  logic                          notime_i,
    output logic                          packet_valid_o,
    input  logic                          packet_ready_i,
    output logic [PAYLOAD_W-1:0]          packet_payload_o,
    output logic [LEN_W-1:0]              payload_length_o,
    output logic                          branch_map_flush_o,
    output logic                          overflow_o,
    output logic [7:0]                    lost_cnt_o
);

    localparam int unsigned BCNT_W = $clog2(BMAP_LEN + 1);

    trdb_format_e           fmt;
    trdb_f_sync_subformat_e sf;
    logic [XLEN-1:0]        last_addr_q;
    logic [XLEN-1:0]        addr;
    logic                   notify;
    logic                   upd_flag;
    logic [2:0]             flags;
    logic                   full_map;
    logic [3:0]             hdr;
    logic [7:0]             hdr_bits;
    logic [7:0]             time_bits;
    logic [7:0]             tail_bits;
    logic [7:0]             total_bits;
    logic [PAYLOAD_W-1:0]   tail;
    logic [PAYLOAD_W-1:0]   time_field;
    logic                   has_addr;
    logic                   flushes;
    emitter_entry_t         new_entry;
    emitter_entry_t         head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   is_req;
    logic                   push;
    logic                   drop;
    logic                   pop;
    logic                   flush_q;
    logic                   overflow_q;
    logic [7:0]             lost_q;

    assign fmt      = trdb_format_e'(format_i);
    assign sf       = trdb_f_sync_subformat_e'(subformat_i);
    assign addr     = full_address_i ? iaddr_i : iaddr_i - last_addr_q;
    assign notify   = addr[XLEN-1];
    assign upd_flag = updiscon_i ? ~notify : notify;
    assign flags    = {notify, upd_flag, upd_flag};
    assign full_map = (branches_i == BCNT_W'(BMAP_LEN));

`ifdef TRDB_EMIT_TIME_EN
    logic [TIME_W-1:0] time_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) time_q <= '0;
        else         time_q <= time_q + 1'b1;
    end

    assign time_bits  = notime_i ? 8'd0 : 8'(TIME_W);
    assign time_field = notime_i ? '0 : PAYLOAD_W'(time_q);
`else
    localparam int unsigned unused_time_w = TIME_W;
    logic unused_notime;

    assign unused_notime = notime_i;
    assign time_bits     = 8'd0;
    assign time_field    = '0;
`endif

    // Header, optional time, then the format-specific tail, all right-aligned.
    always_comb begin
        hdr       = {2'b00, format_i};
        hdr_bits  = 8'd2;
        tail      = '0;
        tail_bits = 8'd0;
        has_addr  = 1'b0;
        flushes   = 1'b0;
        case (fmt)
            F_SYNC: begin
                hdr      = {format_i, subformat_i};
                hdr_bits = 8'd4;
                case (sf)
                    SF_START: begin
                        tail      = PAYLOAD_W'({branch_i, priv_i, addr});
                        tail_bits = 8'(1 + PRIV_LEN + XLEN);
                        has_addr  = 1'b1;
                        flushes   = 1'b1;
                    end
                    SF_EXCEPTION: begin
                        tail      = PAYLOAD_W'({branch_i, priv_i, cause_i, interrupt_i, thaddr_i, addr, tval_i});
                        tail_bits = 8'(1 + PRIV_LEN + CAUSE_LEN + 2 + XLEN + TVAL_LEN);
                        has_addr  = 1'b1;
                        flushes   = 1'b1;
                    end
                    SF_CONTEXT: begin
                        tail      = PAYLOAD_W'(priv_i);
                        tail_bits = 8'(PRIV_LEN);
                    end
                    SF_SUPPORT: begin
                        tail      = PAYLOAD_W'({ienable_i, encoder_mode_i, qual_status_i, ioptions_i});
                        tail_bits = 8'd7;
                    end
                endcase
            end
            F_ADDR_ONLY: begin
                tail      = PAYLOAD_W'({addr, flags});
                tail_bits = 8'(XLEN + 3);
                has_addr  = 1'b1;
            end
            F_DIFF_DELTA: begin
                flushes = 1'b1;
                if (full_map) begin
                    tail      = PAYLOAD_W'({branches_i, branch_map_i});
                    tail_bits = 8'(BCNT_W + BMAP_LEN);
                end else begin
                    tail      = PAYLOAD_W'({branches_i, branch_map_i, addr, flags});
                    tail_bits = 8'(BCNT_W + BMAP_LEN + XLEN + 3);
                    has_addr  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign total_bits        = hdr_bits + time_bits + tail_bits;
    assign new_entry.payload = (PAYLOAD_W'(hdr) << (time_bits + tail_bits))
                             | (time_field << tail_bits)
                             | tail;
    assign new_entry.length  = LEN_W'((total_bits + 8'd7) >> 3);

    // Format 0 is never queued and never counted as lost.
    assign is_req = valid_i && (fmt != F_OPT_EXT);
    assign push   = is_req && !fifo_full;
    assign drop   = is_req && fifo_full;
    assign pop    = packet_valid_o && packet_ready_i;

    trdb_pkt_fifo #(
        .entry_t (emitter_entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (new_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_addr_q <= '0;
            flush_q     <= 1'b0;
            overflow_q  <= 1'b0;
            lost_q      <= '0;
        end else begin
            flush_q <= push && flushes;
            if (push && has_addr) begin
                last_addr_q <= iaddr_i;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (lost_q != 8'hFF) lost_q <= lost_q + 8'd1;
            end
        end
    end

    assign packet_valid_o     = !fifo_empty;
    assign packet_payload_o   = fifo_empty ? '0 : head.payload;
    assign payload_length_o   = fifo_empty ? '0 : head.length;
    assign branch_map_flush_o = flush_q;
    assign overflow_o         = overflow_q;
    assign lost_cnt_o         = lost_q;

endmodule

// File: tb/tb_trdb_packet_emitter_q.sv
// tb/tb_trdb_packet_emitter_q.sv - directed table, corner sequences and randomized model check for trdb_packet_emitter_q
module tb_trdb_packet_emitter_q;
    import trdb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 96;

    typedef struct packed {
        logic        valid;
        logic [1:0]  fmt;
        logic [1:0]  sf;
        logic        full;
        logic        branch;
        logic [1:0]  priv;
        logic [31:0] iaddr;
        logic [4:0]  cause;
        logic        interrupt;
        logic        thaddr;
        logic [31:0] tval;
        logic        updiscon;
        logic [4:0]  branches;
        logic [30:0] bmap;
        logic        ienable;
        logic        encmode;
        logic [1:0]  qual;
        logic [2:0]  iopt;
        logic        notime;
    } req_t;

    typedef struct {
        req_t                 r;
        logic [PAYLOAD_W-1:0] pay;
        logic [4:0]           len;
        logic                 flush;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 ready = 1'b0;
    req_t                 cur = '0;
    logic                 pvalid;
    logic [PAYLOAD_W-1:0] payload;
    logic [4:0]           plen;
    logic                 flush;
    logic                 ovf;
    logic [7:0]           lost;

    int             checks = 0;
    int             errors = 0;
    emitter_entry_t exq[$];
    logic [31:0]    m_last = '0;
    logic           m_flush = 1'b0;
    logic           m_ovf = 1'b0;
    int             m_lost = 0;
    logic [127:0]   m_acc;
    int             m_n;
    vec_t           vecs[$];

    always #5 clk = ~clk;

    trdb_packet_emitter_q #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .valid_i            (cur.valid),
        .format_i           (cur.fmt),
        .subformat_i        (cur.sf),
        .full_address_i     (cur.full),
        .branch_i           (cur.branch),
        .priv_i             (cur.priv),
        .iaddr_i            (cur.iaddr),
        .cause_i            (cur.cause),
        .interrupt_i        (cur.interrupt),
        .thaddr_i           (cur.thaddr),
        .tval_i             (cur.tval),
        .updiscon_i         (cur.updiscon),
        .branches_i         (cur.branches),
        .branch_map_i       (cur.bmap),
        .ienable_i          (cur.ienable),
        .encoder_mode_i     (cur.encmode),
        .qual_status_i      (cur.qual),
        .ioptions_i         (cur.iopt),
        .notime_i           (cur.notime),
        .packet_valid_o     (pvalid),
        .packet_ready_i     (ready),
        .packet_payload_o   (payload),
        .payload_length_o   (plen),
        .branch_map_flush_o (flush),
        .overflow_o         (ovf),
        .lost_cnt_o         (lost)
    );

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [31:0] v, input int w);
        logic [31:0] mask;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        m_acc = (m_acc << w) | {96'd0, v & mask};
        m_n   = m_n + w;
    endfunction

    // Appends fields MSB-first into an accumulator, then sizes by the bit count.
    function automatic emitter_entry_t model_pkt(input req_t r, input logic [31:0] last);
        emitter_entry_t e;
        logic [31:0]    a;
        logic           nt;
        logic           ud;
        a     = r.full ? r.iaddr : r.iaddr - last;
        nt    = a[31];
        ud    = r.updiscon ? ~nt : nt;
        m_acc = '0;
        m_n   = 0;
        add(32'(r.fmt), 2);
        if (r.fmt == 2'd3) begin
            add(32'(r.sf), 2);
            case (r.sf)
                2'd0: begin add(32'(r.branch), 1); add(32'(r.priv), 2); add(a, 32); end
                2'd1: begin
                    add(32'(r.branch), 1); add(32'(r.priv), 2); add(32'(r.cause), 5);
                    add(32'(r.interrupt), 1); add(32'(r.thaddr), 1); add(a, 32); add(r.tval, 32);
                end
                2'd2: add(32'(r.priv), 2);
                default: begin
                    add(32'(r.ienable), 1); add(32'(r.encmode), 1);
                    add(32'(r.qual), 2); add(32'(r.iopt), 3);
                end
            endcase
        end else begin
            if (r.fmt == 2'd1) begin add(32'(r.branches), 5); add(32'(r.bmap), 31); end
            if (r.fmt == 2'd2 || r.branches != 5'd31) begin
                add(a, 32); add(32'(nt), 1); add(32'(ud), 1); add(32'(ud), 1);
            end
        end
        e.payload = m_acc[PAYLOAD_W-1:0];
        e.length  = 5'((m_n + 7) / 8);
        return e;
    endfunction

    function automatic logic carries_addr(input req_t r);
        return (r.fmt == 2'd2) || (r.fmt == 2'd1 && r.branches != 5'd31) || (r.fmt == 2'd3 && r.sf < 2'd2);
    endfunction

    task automatic step();
        logic req;
        logic full_b;
        req     = cur.valid && cur.fmt != 2'd0;
        full_b  = (exq.size() == DEPTH);
        m_flush = 1'b0;
        if (ready && exq.size() > 0) void'(exq.pop_front());
        if (req && full_b) begin
            m_ovf = 1'b1;
            if (m_lost < 255) m_lost++;
        end else if (req) begin
            exq.push_back(model_pkt(cur, m_last));
            if (carries_addr(cur)) m_last = cur.iaddr;
            m_flush = (cur.fmt == 2'd1) || (cur.fmt == 2'd3 && cur.sf < 2'd2);
        end
        @(posedge clk);
        @(negedge clk);
        chk("valid", CW'(pvalid), CW'(exq.size() > 0));
        if (exq.size() > 0) begin
            chk("payload", CW'(payload), CW'(exq[0].payload));
            chk("length", CW'(plen), CW'(exq[0].length));
        end
        chk("flush", CW'(flush), CW'(m_flush));
        chk("overflow", CW'(ovf), CW'(m_ovf));
        chk("lost_cnt", CW'(lost), CW'(m_lost));
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.valid     = ($urandom_range(0, 3) != 0);
        r.fmt       = 2'($urandom_range(0, 3));
        r.sf        = 2'($urandom_range(0, 3));
        r.full      = 1'($urandom_range(0, 1));
        r.branch    = 1'($urandom_range(0, 1));
        r.priv      = 2'($urandom_range(0, 3));
        r.iaddr     = $urandom;
        r.cause     = 5'($urandom_range(0, 31));
        r.interrupt = 1'($urandom_range(0, 1));
        r.thaddr    = 1'($urandom_range(0, 1));
        r.tval      = $urandom;
        r.updiscon  = 1'($urandom_range(0, 1));
        r.branches  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
        r.bmap      = 31'($urandom);
        r.ienable   = 1'($urandom_range(0, 1));
        r.encmode   = 1'($urandom_range(0, 1));
        r.qual      = 2'($urandom_range(0, 3));
        r.iopt      = 3'($urandom_range(0, 7));
        r.notime    = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic add_vec(input req_t r, input logic [PAYLOAD_W-1:0] p, input logic [4:0] l, input logic f);
        vec_t v;
        v.r = r; v.pay = p; v.len = l; v.flush = f;
        vecs.push_back(v);
    endtask

    initial begin
        req_t r;
        r = '0; r.fmt = 2'd3; r.sf = 2'd0; r.full = 1'b1; r.iaddr = 32'h8000_0000; r.priv = 2'd3; r.branch = 1'b1;
        add_vec(r, PAYLOAD_W'({2'b11, 2'b00, 1'b1, 2'b11, 32'h8000_0000}), 5'd5, 1'b1);
        r = '0; r.fmt = 2'd2; r.full = 1'b1; r.iaddr = 32'h1000;
        add_vec(r, PAYLOAD_W'({2'b10, 32'h1000, 3'b000}), 5'd5, 1'b0);
        r = '0; r.fmt = 2'd1; r.branches = 5'd3; r.bmap = 31'h5; r.iaddr = 32'h1010;
        add_vec(r, PAYLOAD_W'({2'b01, 5'd3, 31'h5, 32'h10, 3'b000}), 5'd10, 1'b1);
        r = '0; r.fmt = 2'd1; r.branches = 5'd31; r.bmap = 31'h7FFF_FFFF; r.iaddr = 32'hDEAD_BEEF;
        add_vec(r, PAYLOAD_W'({2'b01, 5'd31, 31'h7FFF_FFFF}), 5'd5, 1'b1);
        r = '0; r.fmt = 2'd2; r.iaddr = 32'h1018;
        add_vec(r, PAYLOAD_W'({2'b10, 32'h8, 3'b000}), 5'd5, 1'b0);
        r = '0; r.fmt = 2'd2; r.full = 1'b1; r.iaddr = 32'h20;
        add_vec(r, PAYLOAD_W'({2'b10, 32'h20, 3'b000}), 5'd5, 1'b0);
        r = '0; r.fmt = 2'd2; r.iaddr = 32'h10;
        add_vec(r, PAYLOAD_W'({2'b10, 32'hFFFF_FFF0, 3'b111}), 5'd5, 1'b0);
        r = '0; r.fmt = 2'd2; r.full = 1'b1; r.iaddr = 32'h20;
        add_vec(r, PAYLOAD_W'({2'b10, 32'h20, 3'b000}), 5'd5, 1'b0);
        r = '0; r.fmt = 2'd2; r.iaddr = 32'h10; r.updiscon = 1'b1;
        add_vec(r, PAYLOAD_W'({2'b10, 32'hFFFF_FFF0, 3'b100}), 5'd5, 1'b0);
        r = '0; r.fmt = 2'd3; r.sf = 2'd2; r.priv = 2'd1;
        add_vec(r, PAYLOAD_W'({2'b11, 2'b10, 2'b01}), 5'd1, 1'b0);
        r = '0; r.fmt = 2'd3; r.sf = 2'd3; r.ienable = 1'b1; r.qual = 2'b10; r.iopt = 3'b101;
        add_vec(r, PAYLOAD_W'({2'b11, 2'b11, 1'b1, 1'b0, 2'b10, 3'b101}), 5'd2, 1'b0);
        r = '0; r.fmt = 2'd3; r.sf = 2'd1; r.full = 1'b1; r.iaddr = 32'h40; r.cause = 5'd11;
        r.interrupt = 1'b1; r.tval = 32'hCAFE_0001;
        add_vec(r, PAYLOAD_W'({2'b11, 2'b01, 1'b0, 2'b00, 5'd11, 1'b1, 1'b0, 32'h40, 32'hCAFE_0001}), 5'd10, 1'b1);

        repeat (2) @(negedge clk);
        chk("rst_valid", CW'(pvalid), CW'(0));
        chk("rst_payload", CW'(payload), CW'(0));
        chk("rst_length", CW'(plen), CW'(0));
        chk("rst_flush", CW'(flush), CW'(0));
        chk("rst_overflow", CW'(ovf), CW'(0));
        chk("rst_lost", CW'(lost), CW'(0));
        rst_ni = 1'b1;
        @(negedge clk);

        ready = 1'b1;
        foreach (vecs[i]) begin
            cur = vecs[i].r;
            cur.valid = 1'b1;
            step();
            chk($sformatf("tbl%0d_payload", i), CW'(payload), CW'(vecs[i].pay));
            chk($sformatf("tbl%0d_length", i), CW'(plen), CW'(vecs[i].len));
            chk($sformatf("tbl%0d_flush", i), CW'(flush), CW'(vecs[i].flush));
            cur.valid = 1'b0;
            step();
        end

        // Six requests into a stalled queue of four.
        ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cur = '0; cur.valid = 1'b1; cur.fmt = 2'd2; cur.full = 1'b1; cur.iaddr = 32'(32'h100 * (k + 1));
            step();
        end
        chk("ovf_sticky", CW'(ovf), CW'(1));
        chk("ovf_lost2", CW'(lost), CW'(2));
        chk("ovf_head0", CW'(payload), CW'({2'b10, 32'h100, 3'b000}));
        cur.valid = 1'b0;
        ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("ovf_head%0d", k), CW'(payload), CW'({2'b10, 32'(32'h100 * (k + 1)), 3'b000}));
        end
        step();
        chk("ovf_drained", CW'(pvalid), CW'(0));

        // Reset with three queued packets.
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cur = '0; cur.valid = 1'b1; cur.fmt = 2'd2; cur.full = 1'b1; cur.iaddr = 32'(32'h500 + k);
            step();
        end
        cur.valid = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", CW'(pvalid), CW'(0));
        chk("mid_rst_payload", CW'(payload), CW'(0));
        chk("mid_rst_length", CW'(plen), CW'(0));
        chk("mid_rst_overflow", CW'(ovf), CW'(0));
        chk("mid_rst_lost", CW'(lost), CW'(0));
        exq.delete();
        m_last = '0; m_flush = 1'b0; m_ovf = 1'b0; m_lost = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        cur = '0; cur.valid = 1'b1; cur.fmt = 2'd2; cur.iaddr = 32'h40;
        step();
        chk("post_rst_diff", CW'(payload), CW'({2'b10, 32'h40, 3'b000}));
        cur.valid = 1'b0;
        ready = 1'b1;
        step();

        // Mostly stalled first so the lost counter reaches saturation.
        for (int i = 0; i < 1000; i++) begin
            cur   = rand_req();
            ready = (i < 700) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
